// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with prescaler, load, clear and terminal-count pulse
//
// Purpose:
//   General-purpose event/tick counter. The count range is 0..MAX_VALUE.
//   It can wrap or saturate at either bound, and it steps once every PRESCALE
//   enabled cycles.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-low reset
//   enable         in   count enable; advances the prescaler
//   up_down        in   1 = count up, 0 = count down
//   clear          in   synchronous clear to 0
//   load           in   synchronous parallel load of load_value (clamped to MAX_VALUE)
//   load_value     in   value to load
//   counter_out    out  registered count
//   terminal_count out  one-cycle pulse following a step at a bound
//   at_max         out  counter_out == MAX_VALUE
//   at_min         out  counter_out == 0

module updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             at_max,
  output logic             at_min
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VALUE);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step_c;

  // The prescaler counts enabled cycles. A step fires on the last cycle of
  // each interval. Clear and load both restart the interval.
  always_comb begin
    pre_d  = pre_q;
    step_c = 1'b0;
    if (clear || load) begin
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        step_c = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Count update. A step taken at either bound raises terminal_count, in
  // both wrap and saturate mode. Every other edge drops it.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (step_c) begin
      if (up_down) begin
        if (count_q >= MAX_V) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign counter_out    = count_q;
  assign terminal_count = tc_q;
  assign at_max         = (count_q == MAX_V);
  assign at_min         = (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - scoreboard bench: randomized stimulus on four counter configurations

module tb_updown_counter;

  localparam int NI   = 4;
  localparam int NCYC = 4000;
  localparam int MX[NI] = '{9, 9, 15, 15};
  localparam int PS[NI] = '{3, 1, 4, 1};
  localparam int ST[NI] = '{0, 1, 1, 0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, enable, up_down, clear, load;
  logic [3:0] load_value;
  logic [3:0] cnt_o  [NI];
  logic       tc_o   [NI];
  logic       amax_o [NI];
  logic       amin_o [NI];

  updown_counter #(.WIDTH(4), .MAX_VALUE(MX[0]), .PRESCALE(PS[0]), .SATURATE(ST[0])) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .counter_out(cnt_o[0]),
    .terminal_count(tc_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));
  updown_counter #(.WIDTH(4), .MAX_VALUE(MX[1]), .PRESCALE(PS[1]), .SATURATE(ST[1])) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .counter_out(cnt_o[1]),
    .terminal_count(tc_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));
  updown_counter #(.WIDTH(4), .MAX_VALUE(MX[2]), .PRESCALE(PS[2]), .SATURATE(ST[2])) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .counter_out(cnt_o[2]),
    .terminal_count(tc_o[2]), .at_max(amax_o[2]), .at_min(amin_o[2]));
  updown_counter #(.WIDTH(4), .MAX_VALUE(MX[3]), .PRESCALE(PS[3]), .SATURATE(ST[3])) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .counter_out(cnt_o[3]),
    .terminal_count(tc_o[3]), .at_max(amax_o[3]), .at_min(amin_o[3]));

  typedef struct packed {
    logic [3:0] c;
    logic       tc;
  } exp_t;

  exp_t expq [NI][$];
  int   m_cnt [NI];
  int   m_en_seen [NI];
  int   tests = 0;
  int   fails = 0;

  // Reference model. It counts enabled cycles since the last restart and
  // steps when a full interval has elapsed. It is stepped once per edge
  // with the inputs that will be sampled at that edge.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      int   tc;
      tc = 0;
      if (!reset) begin
        m_cnt[i] = 0;
        m_en_seen[i] = 0;
      end else if (clear) begin
        m_cnt[i] = 0;
        m_en_seen[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_value) > MX[i]) ? MX[i] : int'(load_value);
        m_en_seen[i] = 0;
      end else if (enable) begin
        m_en_seen[i] = m_en_seen[i] + 1;
        if (m_en_seen[i] == PS[i]) begin
          m_en_seen[i] = 0;
          if (up_down) begin
            tc = (m_cnt[i] == MX[i]) ? 1 : 0;
            if (tc == 1 && ST[i] == 1) m_cnt[i] = MX[i];
            else m_cnt[i] = (m_cnt[i] + 1) % (MX[i] + 1);
          end else begin
            tc = (m_cnt[i] == 0) ? 1 : 0;
            if (tc == 1 && ST[i] == 1) m_cnt[i] = 0;
            else m_cnt[i] = (m_cnt[i] + MX[i]) % (MX[i] + 1);
          end
        end
      end
      e.c  = 4'(m_cnt[i]);
      e.tc = (tc != 0);
      expq[i].push_back(e);
    end
  endtask

  // Driver: inputs change on the falling edge. Direction is sticky so that
  // saturating instances spend time pressed against a bound.
  initial begin
    reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
    @(negedge clock);
    for (int n = 0; n < NCYC; n++) begin
      reset      = (n < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      clear      = ($urandom_range(0, 99) < 4);
      load       = ($urandom_range(0, 99) < 5);
      load_value = 4'($urandom_range(0, 15));
      enable     = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 4) up_down = ~up_down;
      model_edge();
      @(negedge clock);
    end
  end

  // Monitor: samples one time unit after each rising edge and compares
  // every instance against the front of its queue.
  initial begin
    @(negedge clock);
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NI; i++) begin
        exp_t e;
        logic emax, emin;
        tests++;
        if (expq[i].size() == 0) begin
          fails++;
          $display("FAIL scoreboard_empty inst%0d cycle %0d: no expected entry, required one", i, n);
        end else begin
          e    = expq[i].pop_front();
          emax = (int'(e.c) == MX[i]);
          emin = (e.c == 4'd0);
          if (cnt_o[i] !== e.c || tc_o[i] !== e.tc || amax_o[i] !== emax || amin_o[i] !== emin) begin
            fails++;
            $display("FAIL outputs inst%0d cycle %0d: got count=%0d tc=%0b max=%0b min=%0b, required count=%0d tc=%0b max=%0b min=%0b",
                     i, n, cnt_o[i], tc_o[i], amax_o[i], amin_o[i], e.c, e.tc, emax, emin);
          end
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
